cond_unit: RTL and testbench



---
 rtl/cond_unit_pkg.sv | 34 +++
 rtl/cond_unit_if.sv | 39 +++
 rtl/cond_check.sv | 42 ++++
 rtl/cond_unit.sv | 135 +++++++++++++
 tb/tb_cond_unit.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cond_unit_pkg.sv
// cond_unit_pkg: shared definitions for the condition/commit stage.
//   - ARM condition-code encodings (Instr[31:28])
//   - controller state encoding
//   - bit positions of N, Z, C, V inside the 4-bit flag vector
package cond_unit_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_if.sv
// cond_unit_if: decoder/ALU-facing signal bundle of the condition/commit stage.
//   master : decode side (drives Cond, ALUFlags, FlagW, PCS/RegW/MemW/VecW,
//            MultiCycle, ALUDone; receives the committed enables and status)
//   slave  : cond_unit itself
interface cond_unit_if #(
   parameter int CNT_W = 32
);
   logic [3:0]       Cond;
   logic [3:0]       ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS;
   logic             RegW;
   logic             MemW;
   logic             VecW;
   logic             MultiCycle;
   logic             ALUDone;
   logic             PCSrc;
   logic             RegWrite;
   logic             MemWrite;
   logic             VecWrite;
   logic             ALUStart;
   logic             Stall;
   logic [3:0]       Flags;
   logic             Error;
   logic [CNT_W-1:0] RetiredCount;
   logic [CNT_W-1:0] TakenCount;

   modport master (
      output Cond, ALUFlags, FlagW, PCS, RegW, MemW, VecW, MultiCycle, ALUDone,
      input  PCSrc, RegWrite, MemWrite, VecWrite, ALUStart, Stall, Flags, Error,
             RetiredCount, TakenCount
   );

   modport slave (
      input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, VecW, MultiCycle, ALUDone,
      output PCSrc, RegWrite, MemWrite, VecWrite, ALUStart, Stall, Flags, Error,
             RetiredCount, TakenCount
   );
endinterface

// File: rtl/cond_check.sv
// cond_check: purely combinational ARM condition evaluation.
//   cond    in  4  instruction condition field
//   flags   in  4  {N,Z,C,V}
//   cond_ex out 1  instruction executes
module cond_check
   import cond_unit_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      cond_ex = 1'b1;
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL, COND_NV: cond_ex = 1'b1;
         default: cond_ex = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: condition/commit stage behind the instruction decoder.
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high
//   bus    slave side of cond_unit_if (decode enables in, committed enables,
//          ALUStart/Stall handshake, Flags, Error and performance counters out)
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | single-cycle commit, or launch of a multi-cycle ALU op
//   BUSY  | waiting for ALUDone; PC stalled; abandon at timer terminal count
module cond_unit
   import cond_unit_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 64
)(
   input  logic       clk,
   input  logic       reset,
   cond_unit_if.slave bus
);

   localparam int               TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             error_q, error_d;
   logic [3:0]       flags_q, flags_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [CNT_W-1:0] taken_q, taken_d;

   logic cond_ex;
   logic commit;
   logic stall;
   logic alu_start;
   logic pc_src;

   cond_check u_cond_check (
      .cond    (bus.Cond),
      .flags   (flags_q),
      .cond_ex (cond_ex)
   );

   // Timer counts down from TIMEOUT-1 loaded at launch; reaching zero while
   // still BUSY without ALUDone is the TIMEOUT-th BUSY cycle, which abandons.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      error_d   = error_q;
      commit    = 1'b0;
      stall     = 1'b0;
      alu_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.MultiCycle && cond_ex) begin
               alu_start = 1'b1;
               stall     = 1'b1;
               tmr_d     = TMR_LOAD;
               state_d   = BUSY;
            end else begin
               // Not-executed multi-cycle ops also land here; cond_ex gates them.
               commit = 1'b1;
            end
         end
         BUSY: begin
            if (bus.ALUDone) begin
               commit  = 1'b1;
               state_d = IDLE;
            end else if (tmr_q == '0) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               stall = 1'b1;
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pc_src = commit & cond_ex & bus.PCS;

   always_comb begin
      flags_d = flags_q;
      if (commit && cond_ex) begin
         if (bus.FlagW[1]) begin
            flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
         end
         if (bus.FlagW[0]) begin
            flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
            flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
         end
      end
   end

   always_comb begin
      retired_d = retired_q;
      taken_d   = taken_q;
      if (!stall) begin
         retired_d = retired_q + CNT_W'(1);
         if (pc_src) taken_d = taken_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         tmr_q     <= '0;
         error_q   <= 1'b0;
         flags_q   <= '0;
         retired_q <= '0;
         taken_q   <= '0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         error_q   <= error_d;
         flags_q   <= flags_d;
         retired_q <= retired_d;
         taken_q   <= taken_d;
      end
   end

   assign bus.PCSrc        = pc_src;
   assign bus.RegWrite     = commit & cond_ex & bus.RegW;
   assign bus.MemWrite     = commit & cond_ex & bus.MemW;
   assign bus.VecWrite     = commit & cond_ex & bus.VecW;
   assign bus.ALUStart     = alu_start;
   assign bus.Stall        = stall;
   assign bus.Flags        = flags_q;
   assign bus.Error        = error_q;
   assign bus.RetiredCount = retired_q;
   assign bus.TakenCount   = taken_q;

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   cond_unit_if #(.CNT_W(32)) bus();

   cond_unit #(.CNT_W(32), .TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_ret   = '0;
   logic [31:0] exp_taken = '0;

   task automatic clear_inputs();
      bus.Cond       = 4'hE;
      bus.ALUFlags   = 4'h0;
      bus.FlagW      = 2'b00;
      bus.PCS        = 1'b0;
      bus.RegW       = 1'b0;
      bus.MemW       = 1'b0;
      bus.VecW       = 1'b0;
      bus.MultiCycle = 1'b0;
      bus.ALUDone    = 1'b0;
   endtask

   // Advance one clock; the model counts what the cycle just ended should retire.
   task automatic step(input logic stall_exp, input logic taken_exp);
      @(posedge clk);
      #1;
      if (!stall_exp) exp_ret = exp_ret + 1;
      if (!stall_exp && taken_exp) exp_taken = exp_taken + 1;
   endtask

   task automatic set_flags(input logic [3:0] f);
      clear_inputs();
      bus.Cond     = 4'hE;
      bus.FlagW    = 2'b11;
      bus.ALUFlags = f;
      step(1'b0, 1'b0);
      checks++;
      if (bus.Flags !== f) begin
         errors++;
         $display("FAIL set_flags: got %b expected %b", bus.Flags, f);
      end
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset     = 1'b0;
      exp_ret   = '0;
      exp_taken = '0;
      #1;
      checks++;
      if (bus.Flags !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b expected 0000", bus.Flags);
      end
      checks++;
      if (bus.Error !== 1'b0) begin
         errors++; $display("FAIL reset_error: got %b expected 0", bus.Error);
      end
      checks++;
      if (bus.RetiredCount !== 32'd0 || bus.TakenCount !== 32'd0) begin
         errors++;
         $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.RetiredCount, bus.TakenCount);
      end
      checks++;
      if (bus.ALUStart !== 1'b0 || bus.Stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake: got start=%b stall=%b expected 0/0", bus.ALUStart, bus.Stall);
      end
      checks++;
      if ({bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.VecWrite} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_enables: got %b expected 0000",
                  {bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.VecWrite});
      end
   endtask

   task automatic test_adds();
      clear_inputs();
      bus.Cond     = 4'hE;
      bus.FlagW    = 2'b11;
      bus.ALUFlags = 4'b0110;
      bus.RegW     = 1'b1;
      #1;
      checks++;
      if (bus.RegWrite !== 1'b1 || bus.Stall !== 1'b0) begin
         errors++;
         $display("FAIL adds_regwrite: got regw=%b stall=%b expected 1/0", bus.RegWrite, bus.Stall);
      end
      step(1'b0, 1'b0);
      checks++;
      if (bus.Flags !== 4'b0110) begin
         errors++; $display("FAIL adds_flags: got %b expected 0110", bus.Flags);
      end
      checks++;
      if (bus.RetiredCount !== 32'd1) begin
         errors++; $display("FAIL adds_retired: got %0d expected 1", bus.RetiredCount);
      end
      // Only C,V written: N,Z keep 01, C,V take 11.
      bus.FlagW    = 2'b01;
      bus.ALUFlags = 4'b1011;
      step(1'b0, 1'b0);
      checks++;
      if (bus.Flags !== 4'b0111) begin
         errors++; $display("FAIL flagw_cv: got %b expected 0111", bus.Flags);
      end
      // Only N,Z written: N,Z take 10, C,V keep 11.
      bus.FlagW    = 2'b10;
      bus.ALUFlags = 4'b1000;
      step(1'b0, 1'b0);
      checks++;
      if (bus.Flags !== 4'b1011) begin
         errors++; $display("FAIL flagw_nz: got %b expected 1011", bus.Flags);
      end
      // EQ fails (Z=0): neither write nor flag update.
      bus.Cond     = 4'h0;
      bus.FlagW    = 2'b11;
      bus.ALUFlags = 4'b0000;
      #1;
      checks++;
      if (bus.RegWrite !== 1'b0) begin
         errors++; $display("FAIL noexec_regwrite: got %b expected 0", bus.RegWrite);
      end
      step(1'b0, 1'b0);
      checks++;
      if (bus.Flags !== 4'b1011) begin
         errors++; $display("FAIL noexec_flags: got %b expected 1011", bus.Flags);
      end
      clear_inputs();
   endtask

   task automatic test_branch();
      set_flags(4'b0100);
      bus.Cond = 4'h1;
      bus.PCS  = 1'b1;
      #1;
      checks++;
      if (bus.PCSrc !== 1'b0) begin
         errors++; $display("FAIL bne_pcsrc: got %b expected 0", bus.PCSrc);
      end
      step(1'b0, 1'b0);
      checks++;
      if (bus.TakenCount !== exp_taken) begin
         errors++; $display("FAIL bne_taken: got %0d expected %0d", bus.TakenCount, exp_taken);
      end
      bus.Cond = 4'h0;
      #1;
      checks++;
      if (bus.PCSrc !== 1'b1) begin
         errors++; $display("FAIL beq_pcsrc: got %b expected 1", bus.PCSrc);
      end
      step(1'b0, 1'b1);
      checks++;
      if (bus.TakenCount !== exp_taken) begin
         errors++; $display("FAIL beq_taken: got %0d expected %0d", bus.TakenCount, exp_taken);
      end
      clear_inputs();
   endtask

   task automatic test_cond_table();
      logic [3:0]  fset [4];
      logic [15:0] mask [4];
      logic        e;
      // mask bit i = expected CondEx for Cond == i under fset
      fset[0] = 4'b0100; mask[0] = 16'hE6A9;
      fset[1] = 4'b1001; mask[1] = 16'hD65A;
      fset[2] = 4'b0010; mask[2] = 16'hD5A6;
      fset[3] = 4'b1000; mask[3] = 16'hEA9A;
      for (int s = 0; s < 4; s++) begin
         set_flags(fset[s]);
         for (int c = 0; c < 16; c++) begin
            bus.Cond = 4'(c);
            bus.PCS  = 1'b1;
            bus.RegW = 1'b1;
            bus.MemW = 1'b1;
            bus.VecW = 1'b1;
            e = mask[s][c];
            #1;
            checks++;
            if ({bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.VecWrite} !== {4{e}}) begin
               errors++;
               $display("FAIL cond_table flags=%b cond=%h: got %b expected %b", fset[s], c,
                        {bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.VecWrite}, {4{e}});
            end
            step(1'b0, e);
         end
      end
      checks++;
      if (bus.RetiredCount !== exp_ret || bus.TakenCount !== exp_taken) begin
         errors++;
         $display("FAIL cond_table_counters: got %0d/%0d expected %0d/%0d",
                  bus.RetiredCount, bus.TakenCount, exp_ret, exp_taken);
      end
      clear_inputs();
   endtask

   task automatic test_multicycle();
      int starts;
      int stalls;
      set_flags(4'b1001);
      starts = 0;
      stalls = 0;
      bus.MultiCycle = 1'b1;
      bus.Cond       = 4'hE;
      bus.RegW       = 1'b1;
      bus.FlagW      = 2'b11;
      bus.ALUFlags   = 4'b0110;
      // start cycle, BUSY 1, BUSY 2, BUSY 3 with ALUDone
      for (int i = 0; i < 4; i++) begin
         bus.ALUDone = (i == 3);
         if (i == 3) bus.ALUFlags = 4'b0011;
         #1;
         if (bus.ALUStart === 1'b1) starts++;
         if (bus.Stall === 1'b1) stalls++;
         checks++;
         if (bus.RegWrite !== (i == 3)) begin
            errors++; $display("FAIL fmul_regwrite cycle %0d: got %b expected %b", i, bus.RegWrite, (i == 3));
         end
         checks++;
         if (bus.Flags !== 4'b1001) begin
            errors++; $display("FAIL fmul_flags_hold cycle %0d: got %b expected 1001", i, bus.Flags);
         end
         step(i < 3, 1'b0);
      end
      checks++;
      if (starts != 1) begin
         errors++; $display("FAIL fmul_start_count: got %0d expected 1", starts);
      end
      checks++;
      if (stalls != 3) begin
         errors++; $display("FAIL fmul_stall_count: got %0d expected 3", stalls);
      end
      checks++;
      if (bus.Flags !== 4'b0011) begin
         errors++; $display("FAIL fmul_flags: got %b expected 0011", bus.Flags);
      end
      checks++;
      if (bus.RetiredCount !== exp_ret) begin
         errors++; $display("FAIL fmul_retired: got %0d expected %0d", bus.RetiredCount, exp_ret);
      end
      clear_inputs();
   endtask

   task automatic test_notexec_multicycle();
      // Flags are 0011: Z=0 so EQ fails.
      clear_inputs();
      bus.MultiCycle = 1'b1;
      bus.Cond       = 4'h0;
      bus.RegW       = 1'b1;
      #1;
      checks++;
      if ({bus.ALUStart, bus.Stall, bus.RegWrite} !== 3'b000) begin
         errors++;
         $display("FAIL mc_noexec: got start/stall/regw=%b expected 000",
                  {bus.ALUStart, bus.Stall, bus.RegWrite});
      end
      step(1'b0, 1'b0);
      checks++;
      if (bus.RetiredCount !== exp_ret) begin
         errors++; $display("FAIL mc_noexec_retired: got %0d expected %0d", bus.RetiredCount, exp_ret);
      end
      bus.MultiCycle = 1'b0;
      bus.Cond       = 4'hE;
      bus.ALUDone    = 1'b1;
      #1;
      checks++;
      if (bus.RegWrite !== 1'b1 || bus.Stall !== 1'b0) begin
         errors++;
         $display("FAIL mc_noexec_idle: got regw=%b stall=%b expected 1/0", bus.RegWrite, bus.Stall);
      end
      step(1'b0, 1'b0);
      clear_inputs();
   endtask

   task automatic test_timeout();
      clear_inputs();
      bus.MultiCycle = 1'b1;
      bus.Cond       = 4'hE;
      bus.PCS        = 1'b1;
      bus.RegW       = 1'b1;
      bus.MemW       = 1'b1;
      bus.VecW       = 1'b1;
      bus.FlagW      = 2'b11;
      bus.ALUFlags   = 4'b1100;
      #1;
      checks++;
      if (bus.ALUStart !== 1'b1 || bus.Stall !== 1'b1) begin
         errors++;
         $display("FAIL to_start: got start=%b stall=%b expected 1/1", bus.ALUStart, bus.Stall);
      end
      step(1'b1, 1'b0);
      for (int i = 1; i < 4; i++) begin
         #1;
         checks++;
         if ({bus.Stall, bus.ALUStart, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.VecWrite} !== 6'b100000) begin
            errors++;
            $display("FAIL to_busy %0d: got %b expected 100000", i,
                     {bus.Stall, bus.ALUStart, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.VecWrite});
         end
         step(1'b1, 1'b0);
      end
      #1;
      checks++;
      if ({bus.Stall, bus.ALUStart, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.VecWrite, bus.Error} !== 7'b0000000) begin
         errors++;
         $display("FAIL to_abandon: got %b expected 0000000",
                  {bus.Stall, bus.ALUStart, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.VecWrite, bus.Error});
      end
      bus.MultiCycle = 1'b0;
      step(1'b0, 1'b0);
      checks++;
      if (bus.Error !== 1'b1) begin
         errors++; $display("FAIL to_error: got %b expected 1", bus.Error);
      end
      checks++;
      if (bus.Flags !== 4'b0011) begin
         errors++; $display("FAIL to_flags: got %b expected 0011", bus.Flags);
      end
      checks++;
      if (bus.RetiredCount !== exp_ret || bus.TakenCount !== exp_taken) begin
         errors++;
         $display("FAIL to_counters: got %0d/%0d expected %0d/%0d",
                  bus.RetiredCount, bus.TakenCount, exp_ret, exp_taken);
      end
      // Back in IDLE: a plain instruction commits at once.
      checks++;
      if ({bus.Stall, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.VecWrite} !== 5'b01111) begin
         errors++;
         $display("FAIL to_idle: got %b expected 01111",
                  {bus.Stall, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.VecWrite});
      end
      step(1'b0, 1'b1);
      checks++;
      if (bus.Error !== 1'b1 || bus.TakenCount !== exp_taken) begin
         errors++;
         $display("FAIL to_sticky: got err=%b taken=%0d expected 1/%0d", bus.Error, bus.TakenCount, exp_taken);
      end
      clear_inputs();
   endtask

   task automatic test_reset_busy();
      clear_inputs();
      bus.MultiCycle = 1'b1;
      bus.Cond       = 4'hE;
      bus.RegW       = 1'b1;
      #1;
      checks++;
      if (bus.ALUStart !== 1'b1) begin
         errors++; $display("FAIL rb_start: got %b expected 1", bus.ALUStart);
      end
      step(1'b1, 1'b0);
      bus.MultiCycle = 1'b0;
      reset          = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      exp_ret   = '0;
      exp_taken = '0;
      checks++;
      if ({bus.Flags, bus.Error, bus.Stall} !== 6'b000000) begin
         errors++;
         $display("FAIL rb_state: got flags/err/stall=%b expected 000000", {bus.Flags, bus.Error, bus.Stall});
      end
      checks++;
      if (bus.RetiredCount !== 32'd0 || bus.TakenCount !== 32'd0) begin
         errors++;
         $display("FAIL rb_counters: got %0d/%0d expected 0/0", bus.RetiredCount, bus.TakenCount);
      end
      bus.ALUDone = 1'b1;
      #1;
      checks++;
      if ({bus.Stall, bus.ALUStart, bus.RegWrite} !== 3'b001) begin
         errors++;
         $display("FAIL rb_done_ignored: got stall/start/regw=%b expected 001",
                  {bus.Stall, bus.ALUStart, bus.RegWrite});
      end
      step(1'b0, 1'b0);
      checks++;
      if (bus.RetiredCount !== exp_ret || bus.Flags !== 4'b0000) begin
         errors++;
         $display("FAIL rb_after: got ret=%0d flags=%b expected %0d/0000", bus.RetiredCount, bus.Flags, exp_ret);
      end
      clear_inputs();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_adds();
      test_branch();
      test_cond_table();
      test_multicycle();
      test_notexec_multicycle();
      test_timeout();
      test_reset_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
